// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone classic arbiter (ibus read-only, dbus read/write) onto one slave port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed dbus priority.
module wb_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] iwb_adr_i,
   input  logic        iwb_cyc_i,
   input  logic        iwb_stb_i,
   output logic [31:0] iwb_dat_o,
   output logic        iwb_ack_o,
   output logic        iwb_err_o,
   input  logic [31:0] dwb_adr_i,
   input  logic [31:0] dwb_dat_i,
   input  logic        dwb_we_i,
   input  logic [3:0]  dwb_sel_i,
   input  logic        dwb_cyc_i,
   input  logic        dwb_stb_i,
   output logic [31:0] dwb_dat_o,
   output logic        dwb_ack_o,
   output logic        dwb_err_o,
   output logic [31:0] swb_adr_o,
   output logic [31:0] swb_dat_o,
   output logic        swb_we_o,
   output logic [3:0]  swb_sel_o,
   output logic        swb_cyc_o,
   output logic        swb_stb_o,
   input  logic [31:0] swb_dat_i,
   input  logic        swb_ack_i,
   input  logic        swb_err_i,
   output logic [1:0]  grant_o
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

   state_e          state_q;
   logic [1:0]      grant_q;
   logic [CntW-1:0] wdog_q;

   logic i_req, d_req, pick_d, abort, wdog_hit, wdog_fire, slv_done;

   assign i_req    = iwb_cyc_i & iwb_stb_i;
   assign d_req    = dwb_cyc_i & dwb_stb_i;
   assign slv_done = swb_ack_i | swb_err_i;
   assign abort    = ((state_q == StGntI) & ~iwb_cyc_i) | ((state_q == StGntD) & ~dwb_cyc_i);
   assign wdog_hit = (TIMEOUT_CYCLES != 0) && (state_q != StIdle)
                     && (wdog_q == CntW'(TIMEOUT_CYCLES));
   // A late ack on the expiry cycle still completes the transfer cleanly.
   assign wdog_fire = wdog_hit & ~swb_ack_i;
   assign grant_o   = grant_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d_q;
   assign pick_d = ~last_d_q;
`else
   assign pick_d = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         grant_q  <= 2'b00;
         wdog_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               wdog_q <= '0;
               if (d_req && (!i_req || pick_d)) begin
                  state_q  <= StGntD;
                  grant_q  <= 2'b10;
`ifdef ARB_ROUND_ROBIN_EN
                  last_d_q <= 1'b1;
`endif
               end else if (i_req) begin
                  state_q  <= StGntI;
                  grant_q  <= 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
                  last_d_q <= 1'b0;
`endif
               end
            end
            StGntI, StGntD: begin
               if (slv_done || wdog_hit || abort) begin
                  state_q <= StIdle;
                  grant_q <= 2'b00;
               end else if (wdog_q != {CntW{1'b1}}) begin
                  wdog_q <= wdog_q + CntW'(1);
               end
            end
            default: begin
               state_q <= StIdle;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   always_comb begin
      swb_adr_o = '0;
      swb_dat_o = '0;
      swb_we_o  = 1'b0;
      swb_sel_o = 4'h0;
      swb_cyc_o = 1'b0;
      swb_stb_o = 1'b0;
      iwb_dat_o = '0;
      iwb_ack_o = 1'b0;
      iwb_err_o = 1'b0;
      dwb_dat_o = '0;
      dwb_ack_o = 1'b0;
      dwb_err_o = 1'b0;
      // Responses are suppressed while reset is held so an in-flight ack never leaks out.
      unique case (state_q)
         StGntI: begin
            swb_adr_o = iwb_adr_i;
            swb_sel_o = 4'hF;
            swb_cyc_o = ~wdog_hit;
            swb_stb_o = ~wdog_hit;
            iwb_dat_o = swb_dat_i;
            iwb_ack_o = swb_ack_i & iwb_cyc_i & ~rst;
            iwb_err_o = (swb_err_i | wdog_fire) & iwb_cyc_i & ~rst;
         end
         StGntD: begin
            swb_adr_o = dwb_adr_i;
            swb_dat_o = dwb_dat_i;
            swb_we_o  = dwb_we_i;
            swb_sel_o = dwb_sel_i;
            swb_cyc_o = dwb_cyc_i & ~wdog_hit;
            swb_stb_o = dwb_stb_i & ~wdog_hit;
            dwb_dat_o = swb_dat_i;
            dwb_ack_o = swb_ack_i & dwb_cyc_i & ~rst;
            dwb_err_o = (swb_err_i | wdog_fire) & dwb_cyc_i & ~rst;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Scoreboard bench for wb_mem_arbiter: memory slave model, spec-level arbitration/memory model.
`timescale 1ns/1ps
module tb_wb_mem_arbiter;
   localparam int unsigned TO = 16;
   localparam int Never = 1000000;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RoundRobin = 1'b1;
`else
   localparam bit RoundRobin = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] iwb_adr_i = '0;
   logic iwb_cyc_i = 1'b0, iwb_stb_i = 1'b0;
   logic [31:0] iwb_dat_o;
   logic iwb_ack_o, iwb_err_o;
   logic [31:0] dwb_adr_i = '0, dwb_dat_i = '0;
   logic dwb_we_i = 1'b0;
   logic [3:0] dwb_sel_i = 4'h0;
   logic dwb_cyc_i = 1'b0, dwb_stb_i = 1'b0;
   logic [31:0] dwb_dat_o;
   logic dwb_ack_o, dwb_err_o;
   logic [31:0] swb_adr_o, swb_dat_o, swb_dat_i;
   logic swb_we_o, swb_cyc_o, swb_stb_o, swb_ack_i, swb_err_i;
   logic [3:0] swb_sel_o;
   logic [1:0] grant_o;

   always #5 clk = ~clk;

   wb_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
      .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o), .iwb_err_o(iwb_err_o),
      .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i),
      .dwb_sel_i(dwb_sel_i), .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
      .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
      .swb_adr_o(swb_adr_o), .swb_dat_o(swb_dat_o), .swb_we_o(swb_we_o),
      .swb_sel_o(swb_sel_o), .swb_cyc_o(swb_cyc_o), .swb_stb_o(swb_stb_o),
      .swb_dat_i(swb_dat_i), .swb_ack_i(swb_ack_i), .swb_err_i(swb_err_i),
      .grant_o(grant_o)
   );

   typedef struct {logic [31:0] adr; logic [31:0] dat; logic we; logic [3:0] sel;} op_t;
   typedef struct {logic [31:0] data; logic err; logic chk;} rsp_t;

   int checks = 0;
   int errors = 0;
   int unsigned cycle = 0;
   bit mon_en = 1'b0;
   bit model_last_d = 1'b0;
   int last_i_wait = 0;
   op_t iops[$], dops[$];
   rsp_t iq[$], dq[$];
   logic [1:0] gq[$];
   logic [31:0] slv_mem [0:4095];
   logic [31:0] ref_mem [0:4095];

   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Slave: memory with a programmable ack latency (registered ack).
   logic ack_q = 1'b0;
   logic [31:0] rdata_q = '0;
   int wait_cnt = 0;
   int slave_lat = 0;
   assign swb_ack_i = ack_q;
   assign swb_dat_i = rdata_q;
   assign swb_err_i = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         ack_q <= 1'b0;
         wait_cnt <= 0;
      end else if (ack_q) begin
         ack_q <= 1'b0;
         wait_cnt <= 0;
      end else if (swb_cyc_o && swb_stb_o) begin
         if (wait_cnt >= slave_lat) begin
            ack_q <= 1'b1;
            wait_cnt <= 0;
            rdata_q <= swb_we_o ? 32'h0 : slv_mem[swb_adr_o[13:2]];
            if (swb_we_o)
               slv_mem[swb_adr_o[13:2]] <= merge(slv_mem[swb_adr_o[13:2]], swb_dat_o, swb_sel_o);
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end else begin
         wait_cnt <= 0;
      end
   end

   // Monitor
   initial begin
      logic [1:0] grant_prev;
      int unsigned grant_cyc;
      rsp_t r;
      grant_prev = 2'b00;
      grant_cyc = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (grant_o != grant_prev && grant_o != 2'b00) begin
               grant_cyc = cycle;
               if (gq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL grant_unexpected: got %b expected no grant", grant_o);
               end else check("grant_order", 64'(grant_o), 64'(gq.pop_front()));
            end
            grant_prev = grant_o;
            if (grant_o == 2'b01 && swb_cyc_o) begin
               check("ibus_sel", 64'(swb_sel_o), 64'hF);
               check("ibus_we_dat", {swb_we_o, swb_dat_o}, 64'h0);
               check("ibus_adr", 64'(swb_adr_o), 64'(iwb_adr_i));
            end
            if (grant_o == 2'b10 && swb_cyc_o)
               check("dbus_pass", {swb_we_o, swb_sel_o, swb_adr_o, swb_dat_o},
                     {dwb_we_i, dwb_sel_i, dwb_adr_i, dwb_dat_i});
            if (grant_o != 2'b01) check("ibus_quiet", {iwb_ack_o, iwb_err_o, iwb_dat_o}, 64'h0);
            if (grant_o != 2'b10) check("dbus_quiet", {dwb_ack_o, dwb_err_o, dwb_dat_o}, 64'h0);
            if (iwb_ack_o || iwb_err_o) begin
               if (iq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL ibus_unexpected_rsp: got ack=%b err=%b expected none",
                           iwb_ack_o, iwb_err_o);
               end else begin
                  r = iq.pop_front();
                  check("ibus_ack_err", {iwb_ack_o, iwb_err_o}, {!r.err, r.err});
                  if (r.chk && !r.err) check("ibus_data", 64'(iwb_dat_o), 64'(r.data));
                  if (r.err) begin
                     check("wdog_delay", 64'(cycle - grant_cyc), 64'(TO));
                     check("wdog_cyc_low", 64'(swb_cyc_o), 64'h0);
                  end
               end
            end
            if (dwb_ack_o || dwb_err_o) begin
               if (dq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL dbus_unexpected_rsp: got ack=%b err=%b expected none",
                           dwb_ack_o, dwb_err_o);
               end else begin
                  r = dq.pop_front();
                  check("dbus_ack_err", {dwb_ack_o, dwb_err_o}, {!r.err, r.err});
                  if (r.chk && !r.err) check("dbus_data", 64'(dwb_dat_o), 64'(r.data));
                  if (r.err) begin
                     check("wdog_delay", 64'(cycle - grant_cyc), 64'(TO));
                     check("wdog_cyc_low", 64'(swb_cyc_o), 64'h0);
                  end
               end
            end
         end
      end
   end

   task automatic drive_i();
      for (int k = 0; k < iops.size(); k++) begin
         int n;
         n = 0;
         iwb_adr_i = iops[k].adr;
         iwb_cyc_i = 1'b1;
         iwb_stb_i = 1'b1;
         do begin @(negedge clk); n++; end while (!(iwb_ack_o || iwb_err_o) && n < 200);
         last_i_wait = n;
         if (!(iwb_ack_o || iwb_err_o)) begin
            checks++; errors++;
            $display("FAIL ibus_wait: got no response in %0d cycles expected one", n);
         end
         @(posedge clk); #1;
      end
      iwb_cyc_i = 1'b0;
      iwb_stb_i = 1'b0;
   endtask

   task automatic drive_d();
      for (int k = 0; k < dops.size(); k++) begin
         int n;
         n = 0;
         dwb_adr_i = dops[k].adr;
         dwb_dat_i = dops[k].dat;
         dwb_we_i  = dops[k].we;
         dwb_sel_i = dops[k].sel;
         dwb_cyc_i = 1'b1;
         dwb_stb_i = 1'b1;
         do begin @(negedge clk); n++; end while (!(dwb_ack_o || dwb_err_o) && n < 200);
         if (!(dwb_ack_o || dwb_err_o)) begin
            checks++; errors++;
            $display("FAIL dbus_wait: got no response in %0d cycles expected one", n);
         end
         @(posedge clk); #1;
      end
      dwb_cyc_i = 1'b0;
      dwb_stb_i = 1'b0;
      dwb_we_i  = 1'b0;
   endtask

   // Predict grant order and responses from the arbitration policy, then run both masters.
   task automatic run_round(input bit never);
      int pi, pd;
      bit take_d;
      op_t op;
      rsp_t r;
      pi = 0;
      pd = 0;
      while (pi < iops.size() || pd < dops.size()) begin
         if (pi < iops.size() && pd < dops.size()) take_d = RoundRobin ? !model_last_d : 1'b1;
         else take_d = (pd < dops.size());
         model_last_d = take_d;
         if (take_d) op = dops[pd];
         else op = iops[pi];
         r.err  = never;
         r.chk  = !op.we;
         r.data = ref_mem[op.adr[13:2]];
         if (op.we && !never) ref_mem[op.adr[13:2]] = merge(ref_mem[op.adr[13:2]], op.dat, op.sel);
         if (take_d) begin dq.push_back(r); gq.push_back(2'b10); pd++; end
         else begin iq.push_back(r); gq.push_back(2'b01); pi++; end
      end
      @(posedge clk); #1;
      fork
         drive_i();
         drive_d();
      join
      repeat (2) @(posedge clk);
      iops.delete();
      dops.delete();
   endtask

   initial begin
      #500000;
      checks++; errors++;
      $display("FAIL global_timeout: got no end of test expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      logic [31:0] w;
      for (int i = 0; i < 4096; i++) begin
         w = $urandom;
         slv_mem[i] <= w;
         ref_mem[i] = w;
      end
      slv_mem[12'h040] <= 32'h00500093; ref_mem[12'h040] = 32'h00500093;
      slv_mem[12'h800] <= 32'h12345678; ref_mem[12'h800] = 32'h12345678;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_grant", 64'(grant_o), 64'h0);
      check("rst_swb_cyc_stb", {swb_cyc_o, swb_stb_o}, 64'h0);
      check("rst_swb_we_sel", {swb_we_o, swb_sel_o}, 64'h0);
      check("rst_swb_adr", 64'(swb_adr_o), 64'h0);
      check("rst_swb_dat", 64'(swb_dat_o), 64'h0);
      check("rst_master_rsp", {iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o}, 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;

      // Single fetch, then store/load with partial byte selects.
      iops.push_back('{adr: 32'h100, dat: 32'h0, we: 1'b0, sel: 4'hF});
      run_round(1'b0);
      check("fetch_latency", 64'(last_i_wait), 64'd3);
      dops.push_back('{adr: 32'h2000, dat: 32'hDEADBEEF, we: 1'b1, sel: 4'b0011});
      dops.push_back('{adr: 32'h2000, dat: 32'h0, we: 1'b0, sel: 4'hF});
      run_round(1'b0);

      // Simultaneous requests with dbus issuing back-to-back.
      iops.push_back('{adr: 32'h104, dat: 32'h0, we: 1'b0, sel: 4'hF});
      for (int k = 0; k < 3; k++)
         dops.push_back('{adr: 32'h2000 + 32'(4 * k), dat: 32'h0, we: 1'b0, sel: 4'hF});
      run_round(1'b0);

      // Watchdog expiry, then a normal fetch.
      slave_lat = Never;
      dops.push_back('{adr: 32'h3000, dat: 32'hA5A5A5A5, we: 1'b1, sel: 4'hF});
      run_round(1'b1);
      slave_lat = 0;
      iops.push_back('{adr: 32'h100, dat: 32'h0, we: 1'b0, sel: 4'hF});
      run_round(1'b0);

      // Ack lands on the expiry cycle.
      slave_lat = int'(TO) - 1;
      dops.push_back('{adr: 32'h2000, dat: 32'h0, we: 1'b0, sel: 4'hF});
      run_round(1'b0);

      // Reset while dbus is granted and the slave ack is in flight.
      slave_lat = 1;
      gq.push_back(2'b10);
      @(posedge clk); #1;
      dwb_adr_i = 32'h2000; dwb_we_i = 1'b0; dwb_sel_i = 4'hF;
      dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_mid_no_rsp", {iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o}, 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
      model_last_d = 1'b0;
      @(negedge clk);
      check("rst_mid_cyc_grant", {swb_cyc_o, grant_o}, 64'h0);
      slave_lat = 0;
      dops.push_back('{adr: 32'h2000, dat: 32'h0, we: 1'b0, sel: 4'hF});
      run_round(1'b0);

      // Randomized traffic sharing one small address window.
      for (int rnd = 0; rnd < 20; rnd++) begin
         int ni, nd;
         ni = $urandom_range(0, 3);
         nd = $urandom_range(0, 3);
         if (ni == 0 && nd == 0) nd = 1;
         slave_lat = $urandom_range(0, 3);
         for (int k = 0; k < ni; k++)
            iops.push_back('{adr: 32'h1000 + 32'($urandom_range(0, 15) * 4), dat: 32'h0,
                             we: 1'b0, sel: 4'hF});
         for (int k = 0; k < nd; k++)
            dops.push_back('{adr: 32'h1000 + 32'($urandom_range(0, 15) * 4), dat: $urandom,
                             we: 1'($urandom_range(0, 1)), sel: 4'($urandom_range(1, 15))});
         run_round(1'b0);
      end

      repeat (3) @(posedge clk);
      check("sb_drain", 64'(iq.size() + dq.size() + gq.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
